id_ex_stage: RTL and testbench

ID/EX pipeline stage that captures a decoded instruction and presents the operand and control bundle to the downstream ALU: ALU opcode, function code, operands A/B and destination. It performs load-use hazard detection with bubble insertion and operand forwarding from the EX/MEM and MEM/WB stages. It handles downstream backpressure and branch flush, and sits between the decode/register-file stage and the full ALU.

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/id_ex_stage_if.sv | 41 ++++
 rtl/id_ex_stage_fwd_mux.sv | 48 ++++
 rtl/id_ex_stage.sv | 159 +++++++++++++++
 tb/tb_id_ex_stage.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the ID/EX pipeline slice:
//   - DATA_W / REG_AW default widths
//   - ALU opcode encodings driven on id_alu_op / ex_alu_op
//   - operand forward-select enum and the priority helper used by fwd_mux
// ----------------------------------------------------------------------------
package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  // The younger writer (EX/MEM) holds the newer value, so it wins over MEM/WB.
  function automatic fwd_sel_e fwd_pick(input logic exmem_hit, input logic memwb_hit);
    if (exmem_hit)      return FWD_EXMEM;
    else if (memwb_hit) return FWD_MEMWB;
    else                return FWD_NONE;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ----------------------------------------------------------------------------
// id_ex_stage_if
//   Decode-to-ID/EX handshake bundle.
//   master : decode side, drives the instruction fields and id_valid
//   slave  : ID/EX stage, drives id_ready
//   A transfer happens on a rising edge where id_valid & id_ready.
// ----------------------------------------------------------------------------
interface id_ex_stage_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int REG_AW = pipe_pkg::REG_AW
);

  logic              id_valid;
  logic              id_ready;
  logic [1:0]        id_alu_op;
  logic [3:0]        id_func;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic              id_use_imm;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;

  modport master (
    output id_valid, id_alu_op, id_func, id_rs, id_rt, id_rs_data, id_rt_data,
           id_imm, id_use_imm, id_rd, id_reg_write, id_mem_read,
    input  id_ready
  );

  modport slave (
    input  id_valid, id_alu_op, id_func, id_rs, id_rt, id_rs_data, id_rt_data,
           id_imm, id_use_imm, id_rd, id_reg_write, id_mem_read,
    output id_ready
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// ----------------------------------------------------------------------------
// fwd_mux
//   Selects one ALU source operand: EX/MEM result, MEM/WB result, or the
//   register-file data captured in ID/EX. Register 0 is never forwarded.
//   Ports:
//     src                       registered source register index
//     reg_data                  registered register-file data
//     exmem_reg_write/rd/result EX/MEM writer tuple
//     memwb_reg_write/rd/result MEM/WB writer tuple
//     operand                   selected operand
//   EN = 0 disables forwarding (operand is always reg_data).
// ----------------------------------------------------------------------------
module fwd_mux
  import pipe_pkg::*;
#(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int REG_AW = pipe_pkg::REG_AW,
  parameter bit EN     = 1'b1
) (
  input  logic [REG_AW-1:0] src,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] operand
);

  fwd_sel_e sel;
  logic     exmem_hit;
  logic     memwb_hit;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    operand   = reg_data;
    exmem_hit = EN && (src != '0) && exmem_reg_write && (exmem_rd == src);
    memwb_hit = EN && (src != '0) && memwb_reg_write && (memwb_rd == src);
    sel       = fwd_pick(exmem_hit, memwb_hit);
    case (sel)
      FWD_EXMEM: operand = exmem_result;
      FWD_MEMWB: operand = memwb_result;
      default:   operand = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register between decode and the ALU. Captures a decoded
//   instruction, inserts a bubble on a load-use hazard, freezes on downstream
//   backpressure, drops its contents on flush, and forwards EX/MEM and MEM/WB
//   results onto the ALU operands.
//
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     id                decode handshake bundle (id_ex_stage_if.slave)
//     flush             kill the EX-stage contents
//     ex_ready          downstream accepts the current bundle
//     exmem_*, memwb_*  writer tuples of the two later stages
//     ex_*              registered bundle / forwarded operands to the ALU
//
//   Configuration macro FORWARDING_EN:
//     defined   : forwarding active; only a load in EX causes a stall
//     undefined : operands come from registered data only; any valid writer
//                 in EX or EX/MEM with a matching nonzero rd stalls decode
//                 (MEM/WB is covered by register-file write-before-read)
// ----------------------------------------------------------------------------
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int REG_AW = pipe_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  id_ex_stage_if.slave      id,
  input  logic              flush,
  input  logic              ex_ready,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              ex_valid,
  output logic [1:0]        ex_alu_op,
  output logic [3:0]        ex_func,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read
);

`ifdef FORWARDING_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  typedef struct packed {
    logic              valid;
    logic [1:0]        alu_op;
    logic [3:0]        func;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } bundle_t;

  bundle_t           r;
  logic              hz;
  logic              hold;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  // True when the decoding instruction reads register w (rt only counts when
  // it is really used as the B operand).
  function automatic logic reads_reg(input logic [REG_AW-1:0] w,
                                     input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] rt,
                                     input logic              use_imm);
    return (w != '0) && ((w == rs) || ((w == rt) && !use_imm));
  endfunction

  always_comb begin
    hold = r.valid & ~ex_ready;
`ifdef FORWARDING_EN
    // Load data is not available until MEM/WB, so only a load in EX stalls.
    hz = id.id_valid & r.valid & r.mem_read &
         reads_reg(r.rd, id.id_rs, id.id_rt, id.id_use_imm);
`else
    hz = id.id_valid &
         ((r.valid & (r.reg_write | r.mem_read) &
           reads_reg(r.rd, id.id_rs, id.id_rt, id.id_use_imm)) |
          (exmem_reg_write & reads_reg(exmem_rd, id.id_rs, id.id_rt, id.id_use_imm)));
`endif
    id.id_ready = ~hold & ~hz & ~flush;
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r <= '0;
    end else if (flush) begin
      r.valid <= 1'b0;
    end else if (hold) begin
      r <= r;
    end else if (hz) begin
      r.valid <= 1'b0;
    end else begin
      r <= '{valid:     id.id_valid,
             alu_op:    id.id_alu_op,
             func:      id.id_func,
             rs:        id.id_rs,
             rt:        id.id_rt,
             rs_data:   id.id_rs_data,
             rt_data:   id.id_rt_data,
             imm:       id.id_imm,
             use_imm:   id.id_use_imm,
             rd:        id.id_rd,
             reg_write: id.id_reg_write,
             mem_read:  id.id_mem_read};
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .EN(FWD_EN)) u_fwd_a (
    .src             (r.rs),
    .reg_data        (r.rs_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .operand         (fwd_a)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .EN(FWD_EN)) u_fwd_b (
    .src             (r.rt),
    .reg_data        (r.rt_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .operand         (fwd_b)
  );

  assign ex_valid     = r.valid;
  assign ex_alu_op    = r.alu_op;
  assign ex_func      = r.func;
  assign ex_a         = fwd_a;
  assign ex_b         = r.use_imm ? r.imm : fwd_b;
  assign ex_rd        = r.rd;
  assign ex_reg_write = r.reg_write;
  assign ex_mem_read  = r.mem_read;

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
//   Self-checking bench for id_ex_stage. A behavioural model of the stage
//   (bundle contents plus the hazard / hold / forwarding rules) predicts every
//   output; directed scenarios additionally check hand-derived constants.
//   Builds with or without FORWARDING_EN.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;
  import pipe_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          ex_ready;
  logic          exmem_reg_write;
  logic [AW-1:0] exmem_rd;
  logic [DW-1:0] exmem_result;
  logic          memwb_reg_write;
  logic [AW-1:0] memwb_rd;
  logic [DW-1:0] memwb_result;
  logic          ex_valid;
  logic [1:0]    ex_alu_op;
  logic [3:0]    ex_func;
  logic [DW-1:0] ex_a;
  logic [DW-1:0] ex_b;
  logic [AW-1:0] ex_rd;
  logic          ex_reg_write;
  logic          ex_mem_read;

  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(DW), .REG_AW(AW)) id_if ();

  id_ex_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .id              (id_if),
    .flush           (flush),
    .ex_ready        (ex_ready),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .ex_valid        (ex_valid),
    .ex_alu_op       (ex_alu_op),
    .ex_func         (ex_func),
    .ex_a            (ex_a),
    .ex_b            (ex_b),
    .ex_rd           (ex_rd),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read)
  );

  logic [78:0] obs;
  assign obs = {ex_valid, ex_alu_op, ex_func, ex_a, ex_b, ex_rd,
                ex_reg_write, ex_mem_read, id_if.id_ready};

  int n_total = 0;
  int n_pass  = 0;
  int n_prints = 0;

  // Reference model: the instruction currently held in EX.
  logic          m_valid = 0, m_use_imm = 0, m_rw = 0, m_mr = 0;
  logic [1:0]    m_alu_op = 0;
  logic [3:0]    m_func = 0;
  logic [AW-1:0] m_rs = 0, m_rt = 0, m_rd = 0;
  logic [DW-1:0] m_rs_data = 0, m_rt_data = 0, m_imm = 0;

  function automatic logic depends(input logic [AW-1:0] w);
    return (w != 0) && ((w == id_if.id_rs) || ((w == id_if.id_rt) && !id_if.id_use_imm));
  endfunction

  function automatic logic model_hz();
    if (!id_if.id_valid) return 1'b0;
    if (FWD) return m_valid && m_mr && depends(m_rd);
    return (m_valid && (m_rw || m_mr) && depends(m_rd)) ||
           (exmem_reg_write && depends(exmem_rd));
  endfunction

  function automatic logic model_ready();
    return !(m_valid && !ex_ready) && !model_hz() && !flush;
  endfunction

  // Value an ALU source should see: newest pending write to that register.
  function automatic logic [DW-1:0] src_val(input logic [AW-1:0] src, input logic [DW-1:0] rdata);
    if (FWD && src != 0) begin
      if (exmem_reg_write && exmem_rd == src) return exmem_result;
      if (memwb_reg_write && memwb_rd == src) return memwb_result;
    end
    return rdata;
  endfunction

  function automatic logic [78:0] exp_vec();
    logic [DW-1:0] b;
    b = m_use_imm ? m_imm : src_val(m_rt, m_rt_data);
    return {m_valid, m_alu_op, m_func, src_val(m_rs, m_rs_data), b, m_rd,
            m_rw, m_mr, model_ready()};
  endfunction

  // Advance one clock edge, updating the model with the pre-edge inputs.
  task automatic step();
    logic hz_now, hold_now;
    hz_now   = model_hz();
    hold_now = m_valid && !ex_ready;
    @(posedge clk);
    if (rst) begin
      {m_valid, m_alu_op, m_func, m_rs, m_rt, m_rs_data, m_rt_data,
       m_imm, m_use_imm, m_rd, m_rw, m_mr} = '0;
    end else if (flush) begin
      m_valid = 1'b0;
    end else if (hold_now) begin
      m_valid = m_valid;
    end else if (hz_now) begin
      m_valid = 1'b0;
    end else begin
      m_valid = id_if.id_valid;     m_alu_op  = id_if.id_alu_op;
      m_func  = id_if.id_func;      m_rs      = id_if.id_rs;
      m_rt    = id_if.id_rt;        m_rs_data = id_if.id_rs_data;
      m_rt_data = id_if.id_rt_data; m_imm     = id_if.id_imm;
      m_use_imm = id_if.id_use_imm; m_rd      = id_if.id_rd;
      m_rw    = id_if.id_reg_write; m_mr      = id_if.id_mem_read;
    end
    #1;
  endtask

  task automatic drive_idle();
    rst = 0; flush = 0; ex_ready = 1;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    id_if.id_valid = 0; id_if.id_alu_op = 0; id_if.id_func = 0;
    id_if.id_rs = 0; id_if.id_rt = 0; id_if.id_rs_data = 0; id_if.id_rt_data = 0;
    id_if.id_imm = 0; id_if.id_use_imm = 0; id_if.id_rd = 0;
    id_if.id_reg_write = 0; id_if.id_mem_read = 0;
  endtask

  task automatic set_instr(input logic v, input logic [1:0] op, input logic [3:0] fn,
                           input logic [AW-1:0] rs, input logic [DW-1:0] rs_d,
                           input logic [AW-1:0] rt, input logic [DW-1:0] rt_d,
                           input logic [DW-1:0] imm, input logic use_imm,
                           input logic [AW-1:0] rd, input logic rw, input logic mr);
    id_if.id_valid = v; id_if.id_alu_op = op; id_if.id_func = fn;
    id_if.id_rs = rs; id_if.id_rs_data = rs_d; id_if.id_rt = rt; id_if.id_rt_data = rt_d;
    id_if.id_imm = imm; id_if.id_use_imm = use_imm; id_if.id_rd = rd;
    id_if.id_reg_write = rw; id_if.id_mem_read = mr;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1;
    set_instr(1, ALUOP_RTYPE, 4'hF, 5'd3, $urandom, 5'd4, $urandom, $urandom, 0, 5'd7, 1, 1);
    step();
    drive_idle();
    #1;
    n_total++;
    if (obs[78:1] !== '0) $display("FAIL reset_outputs: got %h expected 0", obs[78:1]);
    else n_pass++;
    n_total++;
    if (id_if.id_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", id_if.id_ready);
    else n_pass++;
  endtask

  task automatic test_pass_through();
    drive_idle();
    set_instr(1, ALUOP_RTYPE, 4'b0010, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 0, 5'd9, 1, 0);
    #1;
    n_total++;
    if (id_if.id_ready !== 1'b1) $display("FAIL pass_ready: got %b expected 1", id_if.id_ready);
    else n_pass++;
    step();
    id_if.id_valid = 0;
    #1;
    n_total++;
    if ({ex_valid, ex_alu_op, ex_func, ex_a, ex_b, ex_rd} !==
        {1'b1, 2'b10, 4'b0010, 32'd5, 32'd7, 5'd9})
      $display("FAIL pass_bundle: got v=%b op=%b fn=%h a=%h b=%h rd=%0d expected v=1 op=10 fn=2 a=5 b=7 rd=9",
               ex_valid, ex_alu_op, ex_func, ex_a, ex_b, ex_rd);
    else n_pass++;
  endtask

  task automatic test_forward_priority();
    logic [DW-1:0] exp;
    drive_idle();
    set_instr(1, ALUOP_ADD, 4'h0, 5'd3, 32'h99, 5'd5, 32'h77, 32'd0, 0, 5'd6, 1, 0);
    step();
    id_if.id_valid = 0;
    exmem_reg_write = 1; exmem_rd = 5'd3; exmem_result = 32'h10;
    memwb_reg_write = 1; memwb_rd = 5'd3; memwb_result = 32'h20;
    #1;
    exp = FWD ? 32'h10 : 32'h99;
    n_total++;
    if (ex_a !== exp) $display("FAIL fwd_exmem_wins: got %h expected %h", ex_a, exp);
    else n_pass++;
    exmem_reg_write = 0;
    #1;
    exp = FWD ? 32'h20 : 32'h99;
    n_total++;
    if (ex_a !== exp) $display("FAIL fwd_memwb: got %h expected %h", ex_a, exp);
    else n_pass++;
    n_total++;
    if (obs !== exp_vec()) $display("FAIL fwd_model: got %h expected %h", obs, exp_vec());
    else n_pass++;

    drive_idle();
    set_instr(1, ALUOP_ADD, 4'h0, 5'd0, 32'h44, 5'd7, 32'h66, 32'd0, 0, 5'd6, 1, 0);
    step();
    id_if.id_valid = 0;
    exmem_reg_write = 1; exmem_rd = 5'd0; exmem_result = 32'h10;
    memwb_reg_write = 1; memwb_rd = 5'd0; memwb_result = 32'h20;
    #1;
    n_total++;
    if ({ex_a, ex_b} !== {32'h44, 32'h66})
      $display("FAIL fwd_r0: got a=%h b=%h expected a=44 b=66", ex_a, ex_b);
    else n_pass++;
  endtask

  task automatic test_load_use();
    int   stalls;
    logic accepted, p_valid, p_rw, p_mr, em_load;
    logic [AW-1:0] p_rd;
    drive_idle();
    step();
    set_instr(1, ALUOP_ADD, 4'h0, 5'd1, 32'h100, 5'd2, 32'h200, 32'd0, 0, 5'd4, 1, 1);
    step();
    set_instr(1, ALUOP_RTYPE, 4'h2, 5'd4, 32'hDEAD, 5'd2, 32'h200, 32'd0, 0, 5'd8, 1, 0);
    #1;
    n_total++;
    if (id_if.id_ready !== 1'b0) $display("FAIL lu_stall: got id_ready=%b expected 0", id_if.id_ready);
    else n_pass++;
    stalls = 0; accepted = 0; em_load = 0;
    for (int k = 0; k < 4 && !accepted; k++) begin
      if (id_if.id_ready) accepted = 1;
      else stalls++;
      p_valid = m_valid; p_rw = m_rw; p_mr = m_mr; p_rd = m_rd;
      step();
      // Downstream pipeline advances: EX -> EX/MEM -> MEM/WB.
      memwb_reg_write = exmem_reg_write; memwb_rd = exmem_rd;
      memwb_result    = em_load ? 32'h55 : exmem_result;
      exmem_reg_write = p_valid && p_rw; exmem_rd = p_rd; exmem_result = 32'h1234;
      em_load         = p_valid && p_mr;
      if (accepted) id_if.id_valid = 0;
      #1;
      if (k == 0) begin
        n_total++;
        if (ex_valid !== 1'b0) $display("FAIL lu_bubble: got ex_valid=%b expected 0", ex_valid);
        else n_pass++;
      end
      n_total++;
      if (obs !== exp_vec()) $display("FAIL lu_model: got %h expected %h", obs, exp_vec());
      else n_pass++;
    end
    n_total++;
    if (!accepted) $display("FAIL lu_timeout: dependent not accepted within 4 cycles");
    else n_pass++;
    n_total++;
    if (stalls != (FWD ? 1 : 2)) $display("FAIL lu_stall_len: got %0d expected %0d", stalls, FWD ? 1 : 2);
    else n_pass++;
    n_total++;
    if ({ex_valid, ex_rd, ex_a} !== {1'b1, 5'd8, (FWD ? 32'h55 : 32'hDEAD)})
      $display("FAIL lu_operand: got v=%b rd=%0d a=%h expected v=1 rd=8 a=%h",
               ex_valid, ex_rd, ex_a, FWD ? 32'h55 : 32'hDEAD);
    else n_pass++;
  endtask

  task automatic test_backpressure_flush();
    drive_idle();
    set_instr(1, ALUOP_SUB, 4'h5, 5'd1, 32'h11, 5'd2, 32'h22, 32'd0, 0, 5'd3, 1, 0);
    step();
    set_instr(1, ALUOP_RTYPE, 4'h7, 5'd5, 32'h55, 5'd6, 32'h66, 32'd0, 0, 5'd7, 1, 0);
    ex_ready = 0;
    #1;
    n_total++;
    if (id_if.id_ready !== 1'b0) $display("FAIL bp_ready_c1: got %b expected 0", id_if.id_ready);
    else n_pass++;
    step();
    n_total++;
    if ({ex_valid, ex_func, ex_a, ex_b, ex_rd} !== {1'b1, 4'h5, 32'h11, 32'h22, 5'd3})
      $display("FAIL bp_frozen: got v=%b fn=%h a=%h b=%h rd=%0d expected v=1 fn=5 a=11 b=22 rd=3",
               ex_valid, ex_func, ex_a, ex_b, ex_rd);
    else n_pass++;
    flush = 1;
    #1;
    n_total++;
    if (id_if.id_ready !== 1'b0) $display("FAIL bp_ready_c2: got %b expected 0", id_if.id_ready);
    else n_pass++;
    step();
    flush = 0;
    #1;
    n_total++;
    if (ex_valid !== 1'b0) $display("FAIL bp_flush: got ex_valid=%b expected 0", ex_valid);
    else n_pass++;
    n_total++;
    if (id_if.id_ready !== 1'b1) $display("FAIL bp_ready_c3: got %b expected 1", id_if.id_ready);
    else n_pass++;
    step();
    id_if.id_valid = 0;
    #1;
    n_total++;
    if ({ex_valid, ex_func, ex_rd} !== {1'b1, 4'h7, 5'd7})
      $display("FAIL bp_refill: got v=%b fn=%h rd=%0d expected v=1 fn=7 rd=7", ex_valid, ex_func, ex_rd);
    else n_pass++;

    // Reset while holding.
    rst = 1;
    step();
    rst = 0;
    #1;
    n_total++;
    if (obs !== {78'd0, 1'b1}) $display("FAIL rst_mid_hold: got %h expected %h", obs, {78'd0, 1'b1});
    else n_pass++;

    // Flush coincident with a valid decode: instruction must not be taken.
    ex_ready = 1;
    set_instr(1, ALUOP_ADD, 4'h1, 5'd1, 32'h1, 5'd2, 32'h2, 32'd0, 0, 5'd3, 1, 0);
    flush = 1;
    #1;
    n_total++;
    if (id_if.id_ready !== 1'b0) $display("FAIL flush_ready: got %b expected 0", id_if.id_ready);
    else n_pass++;
    step();
    flush = 0;
    id_if.id_valid = 0;
    #1;
    n_total++;
    if (ex_valid !== 1'b0) $display("FAIL flush_drop: got ex_valid=%b expected 0", ex_valid);
    else n_pass++;
  endtask

  task automatic test_immediate();
    drive_idle();
    set_instr(1, ALUOP_ADD, 4'h0, 5'd1, 32'h10, 5'd6, 32'h33, 32'hFFFF_FFFC, 1, 5'd9, 1, 0);
    step();
    id_if.id_valid = 0;
    exmem_reg_write = 1; exmem_rd = 5'd6; exmem_result = 32'hAAAA;
    memwb_reg_write = 1; memwb_rd = 5'd6; memwb_result = 32'hBBBB;
    #1;
    n_total++;
    if ({ex_a, ex_b} !== {32'h10, 32'hFFFF_FFFC})
      $display("FAIL imm_b: got a=%h b=%h expected a=10 b=fffffffc", ex_a, ex_b);
    else n_pass++;
  endtask

  task automatic test_random();
    logic stalled;
    drive_idle();
    stalled = 0;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      if (!stalled) begin
        set_instr($urandom_range(0, 3) != 0, 2'($urandom_range(0, 2)), 4'($urandom),
                  5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), $urandom,
                  $urandom, $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
      end
      flush           = ($urandom_range(0, 9) == 0);
      ex_ready        = ($urandom_range(0, 3) != 0);
      exmem_reg_write = $urandom_range(0, 1);
      exmem_rd        = 5'($urandom_range(0, 7));
      exmem_result    = $urandom;
      memwb_reg_write = $urandom_range(0, 1);
      memwb_rd        = 5'($urandom_range(0, 7));
      memwb_result    = $urandom;
      #1;
      n_total++;
      if (obs !== exp_vec()) begin
        if (n_prints < 10) $display("FAIL rand_%0d: got %h expected %h", i, obs, exp_vec());
        n_prints++;
      end else n_pass++;
      stalled = id_if.id_valid && !model_ready();
      step();
    end
    drive_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    drive_idle();
    #2;
    test_reset();
    test_pass_through();
    test_forward_priority();
    test_load_use();
    test_backpressure_flush();
    test_immediate();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
